// File: rtl/perf_counter_unit_if.sv
// Read port and snapshot req/valid/ack bundle between a counter host (master) and perf_counter_unit (slave).
// Read data returns one cycle after rd_en; the snapshot bank stays held from snap_valid until snap_ack.
interface perf_counter_unit_if #(
    parameter int CNT_WD = 32
);
    logic              rd_en;
    logic              rd_snap;
    logic [2:0]        rd_addr;
    logic [CNT_WD-1:0] rd_data;
    logic              rd_valid;
    logic              snap_req;
    logic              snap_valid;
    logic              snap_ack;

    modport master (
        output rd_en, rd_snap, rd_addr, snap_req, snap_ack,
        input  rd_data, rd_valid, snap_valid
    );

    modport slave (
        input  rd_en, rd_snap, rd_addr, snap_req, snap_ack,
        output rd_data, rd_valid, snap_valid
    );
endinterface

// File: rtl/perf_counter_unit.sv
// Eight retirement/cycle event counters with sticky wrap flags, a registered read port and a snapshot bank; PERF_OVF_IRQ_EN adds perf_irq.
// Latency: event -> counter 2 cycles, rd_en -> rd_data 1 cycle; no backpressure, snap_req is ignored while a bank is held.
module perf_counter_unit #(
    parameter int CNT_WD = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        real_valid,
    input  logic        real_br_inst,
    input  logic        real_br_pre,
    input  logic        real_br_pre_error,
    input  logic        real_icache_miss,
    input  logic        real_dcache_miss,
    input  logic        real_mem_inst,
    input  logic        cnt_freeze,
    input  logic        cnt_clr,
    output logic [7:0]  ovf_flags,
    input  logic [7:0]  ovf_clr,
    output logic        perf_irq,
    perf_counter_unit_if.slave bus
);
    localparam int NUM_CNT = 8;

    typedef logic [CNT_WD-1:0] cnt_t;
    typedef enum logic {
        SNAP_IDLE,
        SNAP_HOLD
    } snap_state_t;

    logic [NUM_CNT-1:1] ev_in;
    logic [NUM_CNT-1:1] ev_r;
    logic [NUM_CNT-1:0] inc;
    logic [NUM_CNT-1:0] wrap;
    logic               count_en;
    cnt_t               cnt_q  [NUM_CNT];
    cnt_t               bank_q [NUM_CNT];
    logic [7:0]         ovf_q;
    cnt_t               rd_data_q;
    logic               rd_valid_q;
    snap_state_t        state_q;
    snap_state_t        state_d;
    logic               capture;

    // Bit position equals counter index; index 0 is the free-running cycle counter.
    assign ev_in = {real_mem_inst, real_dcache_miss, real_icache_miss,
                    real_br_pre_error, real_br_pre, real_br_inst, real_valid};
    assign inc      = {ev_r, 1'b1};
    assign count_en = !cnt_freeze && !cnt_clr;

    always_comb begin
        wrap = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            wrap[i] = count_en && inc[i] && (cnt_q[i] == '1);
        end
    end

    // Clear also flushes ev_r so events already in flight are discarded.
    always_ff @(posedge clk) begin
        if (!resetn || cnt_clr) begin
            ev_r <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ev_r <= ev_in;
            for (int i = 0; i < NUM_CNT; i++) begin
                if (count_en && inc[i]) begin
                    cnt_q[i] <= cnt_q[i] + cnt_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & ~ovf_clr) | wrap;
        end
    end

    assign ovf_flags = ovf_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= bus.rd_snap ? bank_q[bus.rd_addr] : cnt_q[bus.rd_addr];
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= SNAP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            SNAP_IDLE: begin
                if (bus.snap_req) begin
                    capture = 1'b1;
                    state_d = SNAP_HOLD;
                end
            end
            SNAP_HOLD: begin
                if (bus.snap_ack) begin
                    state_d = SNAP_IDLE;
                end
            end
            default: state_d = SNAP_IDLE;
        endcase
    end

    // Bank captures the pre-edge live values, so it is coherent with what a live read would return.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                bank_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                bank_q[i] <= cnt_q[i];
            end
        end
    end

    assign bus.snap_valid = (state_q == SNAP_HOLD);

`ifdef PERF_OVF_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            irq_q <= 1'b0;
        end else if ((wrap & ~ovf_q) != '0) begin
            irq_q <= 1'b1;
        end else if (ovf_q == '0) begin
            irq_q <= 1'b0;
        end
    end

    assign perf_irq = irq_q;
`else
    assign perf_irq = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_unit.sv
// Randomized plus directed bench for perf_counter_unit with an in-bench behavioural model (CNT_WD=8).
module tb_perf_counter_unit;
    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;
`ifdef PERF_OVF_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       real_valid, real_br_inst, real_br_pre, real_br_pre_error;
    logic       real_icache_miss, real_dcache_miss, real_mem_inst;
    logic       cnt_freeze, cnt_clr;
    logic [7:0] ovf_flags;
    logic [7:0] ovf_clr;
    logic       perf_irq;

    always #5 clk = ~clk;

    perf_counter_unit_if #(.CNT_WD(W)) bus ();

    perf_counter_unit #(.CNT_WD(W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .real_valid        (real_valid),
        .real_br_inst      (real_br_inst),
        .real_br_pre       (real_br_pre),
        .real_br_pre_error (real_br_pre_error),
        .real_icache_miss  (real_icache_miss),
        .real_dcache_miss  (real_dcache_miss),
        .real_mem_inst     (real_mem_inst),
        .cnt_freeze        (cnt_freeze),
        .cnt_clr           (cnt_clr),
        .ovf_flags         (ovf_flags),
        .ovf_clr           (ovf_clr),
        .perf_irq          (perf_irq),
        .bus               (bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    int unsigned m_cnt  [8];
    int unsigned m_bank [8];
    logic [7:1]  m_pend;
    logic [7:0]  m_ovf;
    logic        m_hold;
    logic        m_rd_valid;
    logic        m_irq;
    int unsigned m_rd_data;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each edge applies last cycle's events, freeze/clear rules and the snapshot protocol.
    always @(posedge clk) begin : model_upd
        logic [7:0]  wrapped;
        logic [7:0]  incv;
        logic [7:0]  old_ovf;
        logic [7:1]  evs;
        int unsigned old [8];
        evs = {real_mem_inst, real_dcache_miss, real_icache_miss,
               real_br_pre_error, real_br_pre, real_br_inst, real_valid};
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                m_cnt[i]  = 0;
                m_bank[i] = 0;
            end
            m_pend = '0; m_ovf = '0; m_hold = 1'b0;
            m_rd_valid = 1'b0; m_rd_data = 0; m_irq = 1'b0;
        end else begin
            old     = m_cnt;
            old_ovf = m_ovf;
            wrapped = '0;
            incv    = {m_pend, 1'b1};
            if (cnt_clr) begin
                for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            end else if (!cnt_freeze) begin
                for (int i = 0; i < 8; i++) begin
                    if (incv[i]) begin
                        if (m_cnt[i] == MAXV) begin
                            m_cnt[i]   = 0;
                            wrapped[i] = 1'b1;
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end
                end
            end
            m_ovf      = (m_ovf & ~ovf_clr) | wrapped;
            m_rd_valid = bus.rd_en;
            if (bus.rd_en) m_rd_data = bus.rd_snap ? m_bank[bus.rd_addr] : old[bus.rd_addr];
            if (!m_hold && bus.snap_req) begin
                m_bank = old;
                m_hold = 1'b1;
            end else if (m_hold && bus.snap_ack) begin
                m_hold = 1'b0;
            end
            if ((wrapped & ~old_ovf) != 8'h00) m_irq = 1'b1;
            else if (old_ovf == 8'h00)         m_irq = 1'b0;
            m_pend = cnt_clr ? 7'h00 : evs;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_rd_valid",   bus.rd_valid,   m_rd_valid);
            check("cyc_rd_data",    bus.rd_data,    m_rd_data);
            check("cyc_snap_valid", bus.snap_valid, m_hold);
            check("cyc_ovf_flags",  ovf_flags,      m_ovf);
            check("cyc_perf_irq",   perf_irq,       IRQ_EN ? m_irq : 1'b0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_events(input logic [7:1] e);
        {real_mem_inst, real_dcache_miss, real_icache_miss,
         real_br_pre_error, real_br_pre, real_br_inst, real_valid} = e;
    endtask

    task automatic do_read(input logic [2:0] a, input logic s, input int unsigned exp, input string name);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        bus.rd_snap = s;
        tick;
        bus.rd_en   = 1'b0;
        check({name, "_vld"}, bus.rd_valid, 1);
        check(name, bus.rd_data, exp);
    endtask

    initial begin
        int guard;
        resetn = 1'b0;
        set_events(7'h00);
        cnt_freeze = 1'b0; cnt_clr = 1'b0; ovf_clr = 8'h00;
        bus.rd_en = 1'b0; bus.rd_snap = 1'b0; bus.rd_addr = 3'd0;
        bus.snap_req = 1'b0; bus.snap_ack = 1'b0;
        tick;
        tick;
        chk_en = 1'b1;
        check("rst_rd_valid",   bus.rd_valid,   0);
        check("rst_rd_data",    bus.rd_data,    0);
        check("rst_snap_valid", bus.snap_valid, 0);
        check("rst_ovf",        ovf_flags,      0);
        check("rst_irq",        perf_irq,       0);

        // Idle cycle count after reset release.
        resetn = 1'b1;
        repeat (10) tick;
        do_read(3'd0, 1'b0, 10, "idle_cycles");

        // Five retirements: two branches, one mispredict.
        cnt_clr = 1'b1; tick; cnt_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_events({2'b00, 1'b0, (k == 4) ? 1'b1 : 1'b0, 1'b0, (k < 2) ? 1'b1 : 1'b0, 1'b1});
            tick;
        end
        set_events(7'h00);
        tick;
        do_read(3'd1, 1'b0, 5, "ev_real_valid");
        do_read(3'd2, 1'b0, 2, "ev_br_inst");
        do_read(3'd4, 1'b0, 1, "ev_br_pre_err");
        do_read(3'd3, 1'b0, 0, "ev_br_pre");

        // 256 retirements wrap idx1; bit0 wraps too but is held clear by ovf_clr.
        cnt_clr = 1'b1; ovf_clr = 8'hFF; tick;
        cnt_clr = 1'b0; ovf_clr = 8'h01; real_valid = 1'b1;
        repeat (256) tick;
        real_valid = 1'b0;
        tick;
        check("wrap_ovf", ovf_flags, 8'h02);
        check("wrap_irq", perf_irq, IRQ_EN ? 1 : 0);
        do_read(3'd1, 1'b0, 0, "wrap_idx1");
        ovf_clr = 8'h00;

        // Clear coincident with a cycle-counter wrap and a retirement.
        guard = 0;
        while (m_cnt[0] != 254 && guard < 600) begin
            tick;
            guard++;
        end
        n_cmp++;
        if (guard >= 600) begin
            n_fail++;
            $display("FAIL wait_cyc254: waited %0d cycles want < 600", guard);
        end
        real_valid = 1'b1; ovf_clr = 8'hFD; tick;
        cnt_clr = 1'b1; ovf_clr = 8'h00; tick;
        cnt_clr = 1'b0; real_valid = 1'b0;
        check("clr_ovf", ovf_flags, 8'h02);
        do_read(3'd0, 1'b0, 0, "clr_idx0");
        for (int i = 1; i < 8; i++) do_read(3'(i), 1'b0, 0, "clr_idx");

        // Snapshot at idx1=7, then three more events.
        cnt_clr = 1'b1; tick; cnt_clr = 1'b0;
        real_valid = 1'b1; repeat (7) tick; real_valid = 1'b0;
        tick;
        bus.snap_req = 1'b1; tick; bus.snap_req = 1'b0;
        check("snap_valid_set", bus.snap_valid, 1);
        real_valid = 1'b1; repeat (3) tick; real_valid = 1'b0;
        tick;
        bus.snap_req = 1'b1; tick; bus.snap_req = 1'b0;
        do_read(3'd1, 1'b1, 7,  "snap_idx1");
        do_read(3'd1, 1'b0, 10, "live_idx1");
        bus.snap_ack = 1'b1; tick; bus.snap_ack = 1'b0;
        check("snap_valid_clr", bus.snap_valid, 0);
        do_read(3'd1, 1'b1, 7, "snap_kept");
        bus.snap_req = 1'b1; bus.snap_ack = 1'b1; tick;
        bus.snap_req = 1'b0; bus.snap_ack = 1'b0;
        check("req_ack_hold", bus.snap_valid, 1);
        do_read(3'd1, 1'b1, 10, "req_ack_cap");

        // Reset while holding a bank with a flag set.
        check("pre_rst_ovf1", ovf_flags[1], 1);
        resetn = 1'b0; bus.rd_en = 1'b1; bus.rd_addr = 3'd1; tick;
        bus.rd_en = 1'b0;
        check("rst2_snap_valid", bus.snap_valid, 0);
        check("rst2_ovf",        ovf_flags,      0);
        check("rst2_rd_valid",   bus.rd_valid,   0);
        check("rst2_rd_data",    bus.rd_data,    0);
        check("rst2_irq",        perf_irq,       0);
        resetn = 1'b1;
        do_read(3'd0, 1'b0, 0, "rst2_idx0");
        for (int i = 1; i < 8; i++) do_read(3'(i), 1'b0, 0, "rst2_idx");
        do_read(3'd1, 1'b1, 0, "rst2_bank1");

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            set_events(7'($urandom));
            cnt_freeze   = ($urandom % 16) == 0;
            cnt_clr      = ($urandom % 64) == 0;
            ovf_clr      = (($urandom % 8) == 0) ? 8'($urandom) : 8'h00;
            bus.rd_en    = ($urandom % 4) != 0;
            bus.rd_addr  = 3'($urandom);
            bus.rd_snap  = 1'($urandom);
            bus.snap_req = ($urandom % 8) == 0;
            bus.snap_ack = ($urandom % 8) == 0;
            resetn       = ($urandom % 200) != 0;
            tick;
        end
        set_events(7'h00);
        cnt_freeze = 1'b0; cnt_clr = 1'b0; ovf_clr = 8'h00;
        bus.rd_en = 1'b0; bus.snap_req = 1'b0; bus.snap_ack = 1'b0; resetn = 1'b1;
        tick;
        tick;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
